// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 host transmitter and
//               the PS/2 keyboard receiver path. Holds the transmitter state
//               encoding, common keyboard command bytes, the device ACK byte
//               and the odd-parity helper.
// Optional    : PS2_TX_CLK_FILTER_EN (consumed by ps2_line_sync)
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Transmitter state encoding
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        START     = 3'd2,
        RTS       = 3'd3,
        DATA      = 3'd4,
        PARITY    = 3'd5,
        ACK       = 3'd6,
        WAIT_IDLE = 3'd7
    } ps2_tx_state_e;

    // Host-to-keyboard command bytes
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    // Acknowledge byte returned by the device (seen by the receiver path)
    localparam logic [7:0] DEV_ACK      = 8'hFA;

    // PS/2 frames carry odd parity: the parity bit makes the count of ones
    // across data + parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx_if
// Description : Command handshake between a requester and the PS/2 host
//               transmitter.
//   tx_data  : command byte to send                (master -> slave)
//   tx_valid : request, taken when tx_valid && tx_ready (master -> slave)
//   tx_ready : transmitter idle and able to accept (slave -> master)
//   busy     : frame in progress                    (slave -> master)
//   done     : one-cycle pulse, frame acknowledged  (slave -> master)
//   err      : one-cycle pulse, no ACK or timeout   (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output done,
        output err
    );

endinterface
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_sync
// Description : Conditions the raw PS/2 clock and data pins. Both pins pass
//               through 2-flop synchronizers; a single-cycle falling-edge
//               strobe is derived from the clock level. Shared with the
//               receiver path.
// Optional    : PS2_TX_CLK_FILTER_EN - when defined, the synced clock passes
//               through a glitch filter that only changes level after
//               FILTER_CYCLES consecutive samples of the new value; the edge
//               strobe then follows the filtered level.
// Ports       : clk, rst           - system clock, sync active-high reset
//               ps2_clk_in         - raw PS/2 clock pin (asynchronous)
//               ps2_data_in        - raw PS/2 data pin (asynchronous)
//               clk_level          - conditioned clock level
//               data_level         - synced data level
//               clk_fe             - one-cycle falling-edge strobe of clk_level
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_sync #(
    parameter int unsigned FILTER_CYCLES = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic ps2_clk_in,
    input  wire logic ps2_data_in,
    output logic      clk_level,
    output logic      data_level,
    output logic      clk_fe
);

    logic r_clk_s1;
    logic r_clk_s2;
    logic r_data_s1;
    logic r_data_s2;
    logic r_level_prev;
    logic w_clk_level;

    // Idle PS/2 lines float high, so the synchronizers reset to 1 to avoid a
    // spurious edge right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_data_s1 <= 1'b1;
            r_data_s2 <= 1'b1;
        end else begin
            r_clk_s1  <= ps2_clk_in;
            r_clk_s2  <= r_clk_s1;
            r_data_s1 <= ps2_data_in;
            r_data_s2 <= r_data_s1;
        end
    end

`ifdef PS2_TX_CLK_FILTER_EN
    localparam int unsigned c_filt_w = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [c_filt_w-1:0] c_filt_last = c_filt_w'(FILTER_CYCLES - 1);

    logic [c_filt_w-1:0] r_filt_cnt;
    logic                r_filt;

    // Counts consecutive samples that disagree with the filtered level; any
    // agreeing sample restarts the count, so short glitches never flip it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt     <= 1'b1;
            r_filt_cnt <= '0;
        end else if (r_clk_s2 == r_filt) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == c_filt_last) begin
            r_filt     <= r_clk_s2;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    assign w_clk_level = r_filt;
`else
    assign w_clk_level = r_clk_s2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level_prev <= 1'b1;
        end else begin
            r_level_prev <= w_clk_level;
        end
    end

    assign clk_level  = w_clk_level;
    assign data_level = r_data_s2;
    assign clk_fe     = r_level_prev & ~w_clk_level;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device transmitter. Sends one command byte to
//               the keyboard: inhibits the clock, issues request-to-send,
//               shifts D0..D7, odd parity and stop on device falling edges,
//               then samples the device ACK and waits for an idle bus.
// Optional    : PS2_TX_CLK_FILTER_EN - glitch filter on the PS/2 clock
//               (implemented in ps2_line_sync).
// Ports       : clk, rst        - system clock, sync active-high reset
//               bus (slave)     - tx_data/tx_valid/tx_ready/busy/done/err
//               ps2_clk_in      - raw PS/2 clock pin
//               ps2_data_in     - raw PS/2 data pin
//               ps2_clk_oe      - 1 drives PS/2 clock low, 0 releases it
//               ps2_data_oe     - 1 drives PS/2 data low, 0 releases it
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned FILTER_CYCLES  = 8
) (
    input  wire logic    clk,
    input  wire logic    rst,
    ps2_host_tx_if.slave bus,
    input  wire logic    ps2_clk_in,
    input  wire logic    ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);

    import ps2_pkg::*;

    // One counter serves both the inhibit interval and the edge timeout.
    localparam int unsigned c_cnt_max = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                        INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_inhibit_last = c_cnt_w'(INHIBIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_e      r_state;
    ps2_tx_state_e      w_next_state;

    logic [c_cnt_w-1:0] r_cnt;
    logic [7:0]         r_shreg;
    logic               r_parity;
    logic [3:0]         r_bitcnt;
    logic               r_ack_ok;

    logic               r_tx_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               r_clk_oe;
    logic               r_data_oe;

    logic               w_clk_level;
    logic               w_data_level;
    logic               w_fe;
    logic               w_bus_idle;
    logic               w_in_frame;
    logic               w_timeout;

    logic               w_clk_oe_nxt;
    logic               w_data_oe_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;

    ps2_line_sync #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_line_sync (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .clk_level   (w_clk_level),
        .data_level  (w_data_level),
        .clk_fe      (w_fe)
    );

    assign w_bus_idle = w_clk_level & w_data_level;

    // States where the device owns the clock and the timeout is armed.
    assign w_in_frame = (r_state == RTS)    || (r_state == DATA) ||
                        (r_state == PARITY) || (r_state == ACK)  ||
                        (r_state == WAIT_IDLE);

    // Forward progress (an edge, or the bus going idle) wins over a timeout
    // landing in the same cycle.
    assign w_timeout = w_in_frame && (r_cnt == c_timeout_last) && !w_fe &&
                       !((r_state == WAIT_IDLE) && w_bus_idle);

    // ------------------------------------------------------------------
    // State register (outputs registered alongside from next-state decode)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_tx_ready <= (w_next_state == IDLE);
            r_busy     <= (w_next_state != IDLE);
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_clk_oe   <= w_clk_oe_nxt;
            r_data_oe  <= w_data_oe_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.tx_valid) w_next_state = INHIBIT;
            end
            INHIBIT: begin
                if (r_cnt == c_inhibit_last) w_next_state = START;
            end
            START: begin
                w_next_state = RTS;
            end
            RTS: begin
                if (w_fe)           w_next_state = DATA;
                else if (w_timeout) w_next_state = IDLE;
            end
            DATA: begin
                if (w_fe && (r_bitcnt == 4'd8)) w_next_state = PARITY;
                else if (w_timeout)             w_next_state = IDLE;
            end
            PARITY: begin
                if (w_fe)           w_next_state = ACK;
                else if (w_timeout) w_next_state = IDLE;
            end
            ACK: begin
                if (w_fe)           w_next_state = WAIT_IDLE;
                else if (w_timeout) w_next_state = IDLE;
            end
            WAIT_IDLE: begin
                if (w_bus_idle)     w_next_state = IDLE;
                else if (w_timeout) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_clk_oe_nxt  = (w_next_state == INHIBIT) || (w_next_state == START);
        w_data_oe_nxt = r_data_oe;
        unique case (r_state)
            INHIBIT: w_data_oe_nxt = (w_next_state == START);
            START:   w_data_oe_nxt = 1'b1;
            RTS: begin
                if (w_fe) w_data_oe_nxt = ~r_shreg[0];
            end
            DATA: begin
                // bitcnt holds the index of the next data bit; 8 means all
                // data bits are out and parity goes next.
                if (w_fe) begin
                    w_data_oe_nxt = (r_bitcnt == 4'd8) ? ~r_parity
                                                       : ~r_shreg[r_bitcnt[2:0]];
                end
            end
            PARITY: begin
                if (w_fe) w_data_oe_nxt = 1'b0;
            end
            default: w_data_oe_nxt = 1'b0;
        endcase
        if (w_next_state == IDLE) w_data_oe_nxt = 1'b0;

        w_done_nxt = (r_state == WAIT_IDLE) && w_bus_idle && r_ack_ok;
        w_err_nxt  = ((r_state == WAIT_IDLE) && w_bus_idle && !r_ack_ok) || w_timeout;
    end

    // ------------------------------------------------------------------
    // Datapath: counter, shift register, parity, bit index, ACK flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_shreg  <= '0;
            r_parity <= 1'b0;
            r_bitcnt <= '0;
            r_ack_ok <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (bus.tx_valid) begin
                        r_shreg  <= bus.tx_data;
                        r_parity <= odd_parity(bus.tx_data);
                    end
                end
                INHIBIT: r_cnt <= r_cnt + 1'b1;
                START:   r_cnt <= '0;
                default: r_cnt <= w_fe ? '0 : r_cnt + 1'b1;
            endcase

            if ((r_state == RTS) && w_fe) begin
                r_bitcnt <= 4'd1;
            end else if ((r_state == DATA) && w_fe && (r_bitcnt != 4'd8)) begin
                r_bitcnt <= r_bitcnt + 4'd1;
            end

            if ((r_state == ACK) && w_fe) begin
                r_ack_ok <= ~w_data_level;
            end
        end
    end

    assign bus.tx_ready = r_tx_ready;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign ps2_clk_oe   = r_clk_oe;
    assign ps2_data_oe  = r_data_oe;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Directed self-checking bench for ps2_host_tx. A behavioural
//               keyboard drives the open-drain PS/2 clock, samples the data
//               line in each low phase and optionally ACKs. Short inhibit and
//               timeout values keep the run brief.
// Optional    : PS2_TX_CLK_FILTER_EN - adds a frame with clock glitches.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH    = 100;
    localparam int TMO    = 2000;
    localparam int FILT   = 8;
    localparam int HALF   = 40;   // device clock half period, in clk cycles
    localparam int SAMPLE = 30;   // sample point inside the low phase
    localparam int LIMIT  = 5000; // bound on any wait

    logic clk;
    logic rst;
    logic dev_clk;
    logic dev_data;
    logic ps2_clk_oe;
    logic ps2_data_oe;

    wire ps2_clk_line  = dev_clk  & ~ps2_clk_oe;
    wire ps2_data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_CYCLES  (FILT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;
    int done_cnt;
    int err_cnt;

    initial begin
        done_cnt = 0;
        err_cnt  = 0;
    end

    always @(negedge clk) begin
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.err)  err_cnt  <= err_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_ready(input logic lvl, input string tag);
        int k;
        k = 0;
        while (bus.tx_ready !== lvl && k < LIMIT) begin
            tick(1);
            k++;
        end
        check(tag, {31'd0, bus.tx_ready}, {31'd0, lvl});
    endtask

    // Behavioural keyboard. Called at the first INHIBIT cycle. Measures the
    // inhibit length, waits for request-to-send, then clocks n_fe falling
    // edges; bits[i-1] is the data line sampled after falling edge i.
    task automatic dev_frame(input bit do_ack, input bit glitch, input int n_fe,
                             output logic [9:0] bits, output int inh);
        int k;
        inh  = 0;
        bits = '0;
        k    = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && k < LIMIT) begin
            if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0) inh++;
            tick(1);
            k++;
        end
        tick(5);
        for (int i = 1; i <= n_fe; i++) begin
            if (i == 11) begin
                if (do_ack) dev_data = 1'b0;
                tick(HALF / 2);
            end
            dev_clk = 1'b0;
            tick(SAMPLE);
            if (i <= 10) bits[i-1] = ps2_data_line;
            if (i == n_fe && n_fe < 11) return;
            tick(HALF - SAMPLE);
            dev_clk = 1'b1;
            if (glitch && i >= 2 && i <= 8) begin
                tick(6);
                dev_clk = 1'b0;
                tick(3);
                dev_clk = 1'b1;
                tick(HALF - 9);
            end else begin
                tick(HALF);
            end
        end
        dev_data = 1'b1;
    endtask

    logic [9:0] bits;
    int         inh;
    int         d0;
    int         e0;
    int         k;

    initial begin
        n_pass        = 0;
        n_total       = 0;
        rst           = 1'b1;
        dev_clk       = 1'b1;
        dev_data      = 1'b1;
        bus.tx_data   = 8'h00;
        bus.tx_valid  = 1'b0;
        tick(5);

        // Reset state
        check("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        check("rst_busy",     {31'd0, bus.busy},     32'd0);
        check("rst_done",     {31'd0, bus.done},     32'd0);
        check("rst_err",      {31'd0, bus.err},      32'd0);
        check("rst_clk_oe",   {31'd0, ps2_clk_oe},   32'd0);
        check("rst_data_oe",  {31'd0, ps2_data_oe},  32'd0);
        rst = 1'b0;
        tick(5);

        // 0xED, ACKed
        d0 = done_cnt; e0 = err_cnt;
        bus.tx_data = 8'hED; bus.tx_valid = 1'b1;
        wait_ready(1'b0, "ed_accept");
        bus.tx_valid = 1'b0;
        check("ed_busy", {31'd0, bus.busy}, 32'd1);
        dev_frame(1'b1, 1'b0, 11, bits, inh);
        check("ed_inhibit_len", inh, 32'd100);
        check("ed_data_bits",   {24'd0, bits[7:0]}, 32'h0000_00ED);
        check("ed_parity",      {31'd0, bits[8]},   32'd1);
        check("ed_stop",        {31'd0, bits[9]},   32'd1);
        wait_ready(1'b1, "ed_back_idle");
        tick(3);
        check("ed_done_cnt", done_cnt - d0, 32'd1);
        check("ed_err_cnt",  err_cnt - e0,  32'd0);

        // 0x01 then 0xFF back-to-back, second request held through frame 1
        d0 = done_cnt; e0 = err_cnt;
        bus.tx_data = 8'h01; bus.tx_valid = 1'b1;
        wait_ready(1'b0, "b2b_accept1");
        bus.tx_data = 8'hFF;
        dev_frame(1'b1, 1'b0, 11, bits, inh);
        check("b2b1_data_bits", {24'd0, bits[7:0]}, 32'h0000_0001);
        check("b2b1_parity",    {31'd0, bits[8]},   32'd0);
        wait_ready(1'b1, "b2b_ready1");
        k = 0;
        while (bus.tx_ready === 1'b1 && k < LIMIT) begin
            tick(1);
            k++;
        end
        bus.tx_valid = 1'b0;
        check("b2b_ready_cycles", k, 32'd1);
        dev_frame(1'b1, 1'b0, 11, bits, inh);
        check("b2b2_data_bits", {24'd0, bits[7:0]}, 32'h0000_00FF);
        check("b2b2_parity",    {31'd0, bits[8]},   32'd1);
        wait_ready(1'b1, "b2b_ready2");
        tick(3);
        check("b2b_done_cnt", done_cnt - d0, 32'd2);
        check("b2b_err_cnt",  err_cnt - e0,  32'd0);

        // No ACK: data stays high at fe11
        d0 = done_cnt; e0 = err_cnt;
        bus.tx_data = 8'hF4; bus.tx_valid = 1'b1;
        wait_ready(1'b0, "nack_accept");
        bus.tx_valid = 1'b0;
        dev_frame(1'b0, 1'b0, 11, bits, inh);
        check("nack_data_bits", {24'd0, bits[7:0]}, 32'h0000_00F4);
        wait_ready(1'b1, "nack_idle");
        tick(3);
        check("nack_err_cnt",  err_cnt - e0,  32'd1);
        check("nack_done_cnt", done_cnt - d0, 32'd0);

        // Device never clocks: timeout counted from RTS entry
        d0 = done_cnt; e0 = err_cnt;
        bus.tx_data = 8'hFF; bus.tx_valid = 1'b1;
        wait_ready(1'b0, "tmo_accept");
        bus.tx_valid = 1'b0;
        k = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && k < LIMIT) begin
            tick(1);
            k++;
        end
        k = 0;
        while (bus.err !== 1'b1 && k < TMO + 100) begin
            tick(1);
            k++;
        end
        check("tmo_latency",  k, TMO);
        check("tmo_clk_oe",   {31'd0, ps2_clk_oe},   32'd0);
        check("tmo_data_oe",  {31'd0, ps2_data_oe},  32'd0);
        check("tmo_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        tick(3);
        check("tmo_done_cnt", done_cnt - d0, 32'd0);

        // Reset during DATA after fe4
        bus.tx_data = 8'hED; bus.tx_valid = 1'b1;
        wait_ready(1'b0, "rstm_accept");
        bus.tx_valid = 1'b0;
        dev_frame(1'b1, 1'b0, 4, bits, inh);
        check("rstm_bits_d0_d3", {28'd0, bits[3:0]}, 32'h0000_000D);
        d0 = done_cnt; e0 = err_cnt;
        rst = 1'b1;
        tick(1);
        check("rstm_clk_oe",  {31'd0, ps2_clk_oe},  32'd0);
        check("rstm_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        check("rstm_busy",    {31'd0, bus.busy},    32'd0);
        rst = 1'b0;
        dev_clk = 1'b1;
        tick(20);
        check("rstm_no_done", done_cnt - d0, 32'd0);
        check("rstm_no_err",  err_cnt - e0,  32'd0);

`ifdef PS2_TX_CLK_FILTER_EN
        // 3-cycle low glitches on the clock during DATA are filtered out
        d0 = done_cnt; e0 = err_cnt;
        bus.tx_data = 8'hED; bus.tx_valid = 1'b1;
        wait_ready(1'b0, "glt_accept");
        bus.tx_valid = 1'b0;
        dev_frame(1'b1, 1'b1, 11, bits, inh);
        check("glt_data_bits", {24'd0, bits[7:0]}, 32'h0000_00ED);
        check("glt_parity",    {31'd0, bits[8]},   32'd1);
        check("glt_stop",      {31'd0, bits[9]},   32'd1);
        wait_ready(1'b1, "glt_idle");
        tick(3);
        check("glt_done_cnt", done_cnt - d0, 32'd1);
        check("glt_err_cnt",  err_cnt - e0,  32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
